// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one memory read/write channel among several LSUs.
// One transaction in flight; the consumer ready is held until that consumer drops its valid.
module lsu_mem_arbiter #(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready,
  output logic [31:0]                        grant_count,
  output logic                               busy
);

  localparam int unsigned PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int unsigned IDX_W = PTR_W + 1;
  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_READ_WAIT  = 2'd1;
  localparam logic [1:0] S_WRITE_WAIT = 2'd2;
  localparam logic [1:0] S_RELAY      = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                 gnt_idx_q, gnt_idx_d;
  logic                             gnt_rd_q, gnt_rd_d;
  logic                             mem_rd_valid_q, mem_rd_valid_d;
  logic [ADDR_BITS-1:0]             mem_rd_addr_q, mem_rd_addr_d;
  logic                             mem_wr_valid_q, mem_wr_valid_d;
  logic [ADDR_BITS-1:0]             mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_BITS-1:0]             mem_wr_data_q, mem_wr_data_d;
  logic [NUM_CONSUMERS-1:0]         rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0]         wr_ready_q, wr_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0]                 grant_count_q, grant_count_d;

  logic             found_c;
  logic [PTR_W-1:0] pick_idx_c;
  logic [IDX_W-1:0] cand_w;
  logic [IDX_W-1:0] nxt_w;

  // First requesting consumer at or after rr_ptr, wrapping modulo NUM_CONSUMERS.
  always_comb begin : rr_scan
    found_c    = 1'b0;
    pick_idx_c = '0;
    cand_w     = '0;
    nxt_w      = '0;
    for (int unsigned off = 0; off < NUM_CONSUMERS; off++) begin
      cand_w = {1'b0, rr_ptr_q} + IDX_W'(off);
      if (cand_w >= IDX_W'(NUM_CONSUMERS)) cand_w = cand_w - IDX_W'(NUM_CONSUMERS);
      if (!found_c && (consumer_read_valid[cand_w[PTR_W-1:0]] ||
                       consumer_write_valid[cand_w[PTR_W-1:0]])) begin
        found_c    = 1'b1;
        pick_idx_c = cand_w[PTR_W-1:0];
      end
    end
    nxt_w = {1'b0, pick_idx_c} + IDX_W'(1);
    if (nxt_w >= IDX_W'(NUM_CONSUMERS)) nxt_w = '0;
  end

  always_comb begin : fsm_next
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_idx_d      = gnt_idx_q;
    gnt_rd_d       = gnt_rd_q;
    mem_rd_valid_d = mem_rd_valid_q;
    mem_rd_addr_d  = mem_rd_addr_q;
    mem_wr_valid_d = mem_wr_valid_q;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    rd_ready_d     = rd_ready_q;
    wr_ready_d     = wr_ready_q;
    rd_data_d      = rd_data_q;
    grant_count_d  = grant_count_q;
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          gnt_idx_d     = pick_idx_c;
          rr_ptr_d      = nxt_w[PTR_W-1:0];
          grant_count_d = grant_count_q + CNT_W'(1);
          // Read wins when the same consumer asks for both; its write waits for a later grant.
          if (consumer_read_valid[pick_idx_c]) begin
            gnt_rd_d       = 1'b1;
            mem_rd_valid_d = 1'b1;
            mem_rd_addr_d  = consumer_read_address[32'(pick_idx_c)*ADDR_BITS +: ADDR_BITS];
            state_d        = S_READ_WAIT;
          end else begin
            gnt_rd_d       = 1'b0;
            mem_wr_valid_d = 1'b1;
            mem_wr_addr_d  = consumer_write_address[32'(pick_idx_c)*ADDR_BITS +: ADDR_BITS];
            mem_wr_data_d  = consumer_write_data[32'(pick_idx_c)*DATA_BITS +: DATA_BITS];
            state_d        = S_WRITE_WAIT;
          end
        end
      end
      S_READ_WAIT: begin
        if (mem_read_ready) begin
          mem_rd_valid_d                                       = 1'b0;
          rd_data_d[32'(gnt_idx_q)*DATA_BITS +: DATA_BITS]     = mem_read_data;
          rd_ready_d[gnt_idx_q]                                = 1'b1;
          state_d                                              = S_RELAY;
        end
      end
      S_WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_wr_valid_d        = 1'b0;
          wr_ready_d[gnt_idx_q] = 1'b1;
          state_d               = S_RELAY;
        end
      end
      S_RELAY: begin
        if (gnt_rd_q ? !consumer_read_valid[gnt_idx_q] : !consumer_write_valid[gnt_idx_q]) begin
          rd_ready_d[gnt_idx_q] = 1'b0;
          wr_ready_d[gnt_idx_q] = 1'b0;
          state_d               = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      gnt_idx_q      <= '0;
      gnt_rd_q       <= 1'b0;
      mem_rd_valid_q <= 1'b0;
      mem_rd_addr_q  <= '0;
      mem_wr_valid_q <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      rd_ready_q     <= '0;
      wr_ready_q     <= '0;
      rd_data_q      <= '0;
      grant_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      gnt_idx_q      <= gnt_idx_d;
      gnt_rd_q       <= gnt_rd_d;
      mem_rd_valid_q <= mem_rd_valid_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      rd_ready_q     <= rd_ready_d;
      wr_ready_q     <= wr_ready_d;
      rd_data_q      <= rd_data_d;
      grant_count_q  <= grant_count_d;
    end
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_read_data   = rd_data_q;
  assign consumer_write_ready = wr_ready_q;
  assign mem_read_valid       = mem_rd_valid_q;
  assign mem_read_address     = mem_rd_addr_q;
  assign mem_write_valid      = mem_wr_valid_q;
  assign mem_write_address    = mem_wr_addr_q;
  assign mem_write_data       = mem_wr_data_q;
  assign grant_count          = grant_count_q;
  assign busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: directed scenarios plus random request batches
// checked against a transaction-level round-robin model and a memory responder.
module tb_lsu_mem_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    consumer_read_valid, consumer_read_ready;
  logic [N*AW-1:0] consumer_read_address;
  logic [N*DW-1:0] consumer_read_data;
  logic [N-1:0]    consumer_write_valid, consumer_write_ready;
  logic [N*AW-1:0] consumer_write_address;
  logic [N*DW-1:0] consumer_write_data;
  logic            mem_read_valid, mem_read_ready;
  logic [AW-1:0]   mem_read_address;
  logic [DW-1:0]   mem_read_data;
  logic            mem_write_valid, mem_write_ready;
  logic [AW-1:0]   mem_write_address;
  logic [DW-1:0]   mem_write_data;
  logic [31:0]     grant_count;
  logic            busy;

  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .grant_count(grant_count), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int rd_lat = 1;
  int wr_lat = 1;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] last_wa, last_wd;
  bit         rd_pend [N];
  bit         wr_pend [N];
  logic [7:0] rd_addr [N];
  logic [7:0] wr_addr [N];
  logic [7:0] wr_dat [N];
  logic [7:0] exp_rdata [N];
  int model_rr, exp_gc, mrv_cycles;
  int order_q [$];
  logic prev_mrv, prev_mwv;
  logic [7:0] prev_mra, prev_mwa, prev_mwd;

  // Memory responder: ready after rd_lat/wr_lat cycles of valid, garbage data otherwise.
  initial begin
    int rc, wc;
    rc = 0; wc = 0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    last_wa = '0; last_wd = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        rc = 0; wc = 0; mem_read_ready = 1'b0; mem_write_ready = 1'b0;
      end else begin
        if (mem_read_valid) begin
          rc++;
          mem_read_ready = (rc == rd_lat);
          mem_read_data  = (rc == rd_lat) ? mem[mem_read_address] : 8'($urandom);
        end else begin
          rc = 0; mem_read_ready = 1'b0; mem_read_data = 8'($urandom);
        end
        if (mem_write_valid) begin
          wc++;
          mem_write_ready = (wc == wr_lat);
          if (wc == wr_lat) begin
            mem[mem_write_address] = mem_write_data;
            last_wa = mem_write_address;
            last_wd = mem_write_data;
          end
        end else begin
          wc = 0; mem_write_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      consumer_read_valid[i]            = rd_pend[i];
      consumer_read_address[i*AW +: AW] = rd_addr[i];
      consumer_write_valid[i]           = wr_pend[i];
      consumer_write_address[i*AW +: AW] = wr_addr[i];
      consumer_write_data[i*DW +: DW]    = wr_dat[i];
    end
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (rd_pend[i] || wr_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference round-robin choice from the current pending set.
  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      int c = (model_rr + k) % N;
      if (rd_pend[c] || wr_pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    chk("mem_valid_excl", 32'(mem_read_valid & mem_write_valid), 0);
    chk("one_ready", 32'($countones({consumer_read_ready, consumer_write_ready}) <= 1), 1);
    if (mem_read_valid && prev_mrv) chk("mra_stable", 32'(mem_read_address), 32'(prev_mra));
    if (mem_write_valid && prev_mwv) begin
      chk("mwa_stable", 32'(mem_write_address), 32'(prev_mwa));
      chk("mwd_stable", 32'(mem_write_data), 32'(prev_mwd));
    end
    if (mem_read_valid) mrv_cycles++;
    prev_mrv = mem_read_valid; prev_mra = mem_read_address;
    prev_mwv = mem_write_valid; prev_mwa = mem_write_address; prev_mwd = mem_write_data;
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) begin
      rd_pend[i] = 0; wr_pend[i] = 0; exp_rdata[i] = '0;
    end
    drive_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_rr = 0; exp_gc = 0;
    chk("rst_grant_count", grant_count, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_valids", 32'({mem_read_valid, mem_write_valid}), 0);
    chk("rst_mem_addr_data", {8'h0, mem_read_address, mem_write_address, mem_write_data}, 0);
    chk("rst_readys", 32'({consumer_read_ready, consumer_write_ready}), 0);
    chk("rst_rdata", 32'(consumer_read_data), 0);
    prev_mrv = 0; prev_mwv = 0; prev_mra = '0; prev_mwa = '0; prev_mwd = '0;
  endtask

  // Apply the pending set and run until the model sees every request completed.
  task automatic run_batch(input string tag, input int budget);
    int cyc = 0;
    int seen, e;
    bit is_rd;
    mrv_cycles = 0;
    drive_inputs();
    while (any_pending() && cyc < budget) begin
      tick();
      cyc++;
      seen = -1; is_rd = 0;
      for (int i = 0; i < N; i++) begin
        if (consumer_read_ready[i]) begin seen = i; is_rd = 1; end
        else if (consumer_write_ready[i]) seen = i;
      end
      if (seen >= 0) begin
        e = model_pick();
        chk({tag, "_grant_idx"}, seen, e);
        if (e >= 0) chk({tag, "_grant_is_read"}, 32'(is_rd), 32'(rd_pend[e]));
        if (is_rd) begin
          exp_rdata[seen] = ref_mem[rd_addr[seen]];
          rd_pend[seen] = 0;
          for (int j = 0; j < N; j++)
            chk({tag, "_rdata"}, 32'(consumer_read_data[j*DW +: DW]), 32'(exp_rdata[j]));
        end else begin
          chk({tag, "_wr_addr"}, 32'(last_wa), 32'(wr_addr[seen]));
          chk({tag, "_wr_data"}, 32'(last_wd), 32'(wr_dat[seen]));
          ref_mem[wr_addr[seen]] = wr_dat[seen];
          wr_pend[seen] = 0;
        end
        model_rr = (seen + 1) % N;
        exp_gc++;
        order_q.push_back(seen * 2 + (is_rd ? 0 : 1));
        drive_inputs();
      end
    end
    chk({tag, "_all_done"}, 32'(any_pending()), 0);
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_grant_count"}, grant_count, exp_gc);
    chk({tag, "_idle_readys"}, 32'({consumer_read_ready, consumer_write_ready}), 0);
  endtask

  initial begin
    int exp_ord [8] = '{0, 2, 4, 6, 0, 2, 4, 6};
    int found;
    bit [1:0] sel;
    reset = 1'b1;
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'(a) ^ 8'h5A;
      ref_mem[a] = mem[a];
    end
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = '0; wr_addr[i] = '0; wr_dat[i] = '0;
    end
    reset_dut();

    // Consumer 2 read of 0x10 with three-cycle memory latency.
    rd_lat = 3;
    mem[8'h10] = 8'hAB; ref_mem[8'h10] = 8'hAB;
    rd_pend[2] = 1; rd_addr[2] = 8'h10;
    order_q.delete();
    run_batch("r033", 40);
    chk("r033_mrv_cycles", mrv_cycles, 3);
    chk("r033_order", order_q.size() == 1 ? order_q[0] : -1, 4);
    chk("r033_slice2", 32'(consumer_read_data[2*DW +: DW]), 32'h0AB);
    chk("r033_grant_count", grant_count, 1);

    // All four read together from reset, then again.
    reset_dut();
    rd_lat = 1;
    order_q.delete();
    for (int i = 0; i < N; i++) begin rd_pend[i] = 1; rd_addr[i] = 8'($urandom); end
    run_batch("r034a", 60);
    for (int i = 0; i < N; i++) begin rd_pend[i] = 1; rd_addr[i] = 8'($urandom); end
    run_batch("r034b", 60);
    chk("r034_count", order_q.size(), 8);
    for (int k = 0; k < 8 && k < order_q.size(); k++) chk("r034_order", order_q[k], exp_ord[k]);

    // Consumer 1 read and write at once: read first.
    order_q.delete();
    wr_lat = 2;
    rd_pend[1] = 1; rd_addr[1] = 8'h05;
    wr_pend[1] = 1; wr_addr[1] = 8'h06; wr_dat[1] = 8'h77;
    run_batch("r035", 60);
    chk("r035_count", order_q.size(), 2);
    chk("r035_first", order_q.size() > 0 ? order_q[0] : -1, 2);
    chk("r035_second", order_q.size() > 1 ? order_q[1] : -1, 3);
    chk("r035_wr_addr", 32'(last_wa), 32'h06);
    chk("r035_wr_data", 32'(last_wd), 32'h77);

    // Consumer 3 keeps read valid two cycles after ready.
    rd_lat = 1;
    mrv_cycles = 0;
    rd_pend[3] = 1; rd_addr[3] = 8'h21;
    drive_inputs();
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      tick();
      if (consumer_read_ready[3]) found = 1;
    end
    chk("r037_ready_seen", found, 1);
    exp_rdata[3] = ref_mem[8'h21];
    chk("r037_slice3", 32'(consumer_read_data[3*DW +: DW]), 32'(exp_rdata[3]));
    repeat (2) begin
      tick();
      chk("r037_hold_ready", 32'(consumer_read_ready[3]), 1);
      chk("r037_hold_busy", 32'(busy), 1);
    end
    rd_pend[3] = 0;
    drive_inputs();
    tick();
    chk("r037_ready_clear", 32'(consumer_read_ready[3]), 0);
    chk("r037_idle", 32'(busy), 0);
    chk("r037_single_read", mrv_cycles, 1);
    model_rr = 0; exp_gc++;
    chk("r037_grant_count", grant_count, exp_gc);

    // Random batches; the round-robin pointer carries over between them.
    for (int b = 0; b < 25; b++) begin
      rd_lat = $urandom_range(1, 4);
      wr_lat = $urandom_range(1, 4);
      for (int i = 0; i < N; i++) begin
        sel = 2'($urandom_range(0, 3));
        rd_pend[i] = sel[0]; wr_pend[i] = sel[1];
        rd_addr[i] = 8'($urandom); wr_addr[i] = 8'($urandom); wr_dat[i] = 8'($urandom);
      end
      run_batch("rnd", 250);
      repeat ($urandom_range(0, 3)) tick();
      chk("rnd_quiet_count", grant_count, exp_gc);
      chk("rnd_quiet_busy", 32'(busy), 0);
    end

    // Reset in the middle of a long write.
    wr_lat = 10;
    wr_pend[0] = 1; wr_addr[0] = 8'h33; wr_dat[0] = 8'h44;
    drive_inputs();
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      tick();
      if (mem_write_valid) found = 1;
    end
    chk("r036_write_started", found, 1);
    tick();
    chk("r036_busy_before", 32'(busy), 1);
    reset_dut();
    repeat (15) begin
      tick();
      chk("r036_no_write_ready", 32'(consumer_write_ready), 0);
      chk("r036_no_mem_write", 32'(mem_write_valid), 0);
    end
    chk("r036_grant_count", grant_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
